// File: rtl/floo_vc_credit_tracker.sv
// Credit and VC-reservation tracker for one router output port.
// Counts free slots in each downstream VC, holds wormhole locks between
// head and tail flits, and precomputes a VC choice for every preferred VC
// so that VC assignment only has to index the result.
module floo_vc_credit_tracker #(
  parameter int unsigned NumVC       = 4,
  parameter int unsigned NumVCWidth  = NumVC > 1 ? $clog2(NumVC) : 1,
  parameter int unsigned VCDepth     = 3,
  parameter int unsigned CreditWidth = $clog2(VCDepth + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              sent_v_i,
  input  logic [NumVCWidth-1:0]             sent_id_i,
  input  logic                              sent_last_i,
  input  logic                              credit_v_i,
  input  logic [NumVCWidth-1:0]             credit_id_i,
  output logic [NumVC-1:0]                  vc_selection_v_o,
  output logic [NumVC*NumVCWidth-1:0]       vc_selection_id_o,
  output logic [NumVC*CreditWidth-1:0]      vc_credit_o,
  output logic [NumVC-1:0]                  vc_locked_o
);

  localparam logic [CreditWidth-1:0] MaxCredit = CreditWidth'(VCDepth);
  localparam logic [CreditWidth-1:0] OneCredit = CreditWidth'(1);

  logic [NumVC-1:0][CreditWidth-1:0] credit_d, credit_q;
  logic [NumVC-1:0]                  locked_d, locked_q;
  logic [NumVC-1:0]                  dec, inc, avail;
  logic [NumVC-1:0][NumVCWidth-1:0]  sel_id;
  logic [NumVC-1:0]                  sel_v;
  logic                              low_v;
  logic [NumVCWidth-1:0]             low_id;

  // Next-state credits and locks; simultaneous send and return on one VC cancel,
  // and counters saturate at 0 and VCDepth instead of wrapping.
  always_comb begin
    credit_d = credit_q;
    locked_d = locked_q;
    dec      = '0;
    inc      = '0;
    for (int i = 0; i < NumVC; i++) begin
      dec[i] = sent_v_i && (sent_id_i == NumVCWidth'(i));
      inc[i] = credit_v_i && (credit_id_i == NumVCWidth'(i));
      if (dec[i] && !inc[i] && (credit_q[i] != '0)) begin
        credit_d[i] = credit_q[i] - OneCredit;
      end else if (inc[i] && !dec[i] && (credit_q[i] != MaxCredit)) begin
        credit_d[i] = credit_q[i] + OneCredit;
      end
      // A head or body flit reserves the VC, the tail releases it.
      if (dec[i]) begin
        locked_d[i] = ~sent_last_i;
      end
    end
  end

  // State registers; reset restores a full, unreserved downstream buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credit_q <= {NumVC{MaxCredit}};
      locked_q <= '0;
    end else begin
      credit_q <= credit_d;
      locked_q <= locked_d;
    end
  end

  // Selection from registered state only, so any event shows up one cycle later.
  always_comb begin
    avail  = '0;
    low_v  = 1'b0;
    low_id = '0;
    sel_v  = '0;
    sel_id = '0;
    for (int i = 0; i < NumVC; i++) begin
      avail[i] = (credit_q[i] != '0) && !locked_q[i];
    end
    for (int i = 0; i < NumVC; i++) begin
      if (avail[i] && !low_v) begin
        low_v  = 1'b1;
        low_id = NumVCWidth'(i);
      end
    end
    for (int p = 0; p < NumVC; p++) begin
      if (avail[p]) begin
        sel_v[p]  = 1'b1;
        sel_id[p] = NumVCWidth'(p);
      end else if (low_v) begin
        sel_v[p]  = 1'b1;
        sel_id[p] = low_id;
      end else begin
        sel_v[p]  = 1'b0;
        sel_id[p] = NumVCWidth'(p);
      end
    end
  end

  assign vc_selection_v_o  = sel_v;
  assign vc_selection_id_o = sel_id;
  assign vc_credit_o       = credit_q;
  assign vc_locked_o       = locked_q;

`ifndef SYNTHESIS
  // Protocol checks: credit underflow/overflow and VC ids beyond NumVC.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      if (sent_v_i) begin
        assert (int'(sent_id_i) < int'(NumVC))
          else $warning("sent_id_i out of range: %0d", sent_id_i);
      end
      if (credit_v_i) begin
        assert (int'(credit_id_i) < int'(NumVC))
          else $warning("credit_id_i out of range: %0d", credit_id_i);
      end
      for (int i = 0; i < NumVC; i++) begin
        assert (!(dec[i] && !inc[i] && (credit_q[i] == '0)))
          else $warning("credit underflow on VC %0d", i);
        assert (!(inc[i] && !dec[i] && (credit_q[i] == MaxCredit)))
          else $warning("credit overflow on VC %0d", i);
      end
    end
  end
`endif

endmodule
